sid_write_arbiter: RTL and testbench
====================================

Name: sid_write_arbiter

Overview:
- Shares the single SID register-write bus (the iWE/iAddr/iData port of the voice bank) between two requesters: host CPU bus (port A) and internal tune player (port B).
- Round-robin arbitration; accepted writes are buffered in a small FIFO.
- Writes are issued one at a time with a programmable minimum spacing and optional alignment to the 1 MHz clkEn strobe.
- Sits between the bus front-ends and sid_voices.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- MIN_GAP, 0, idle clk cycles forced between consecutive issued writes (0..255).
- ISSUE_ON_CLKEN, 1, 1 = issue only in cycles where clkEn=1; 0 = issue in any cycle.
- MAX_ADDR, 5'h18, highest writable register address; higher addresses are dropped.

Ports:
- clk  in  1  master clock
- iRst  in  1  asynchronous active-high reset
- clkEn  in  1  1 MHz enable strobe
- iValidA  in  1  requester A write valid
- iAddrA  in  5  requester A register address
- iDataA  in  8  requester A write data
- oReadyA  out  1  requester A accepted this cycle
- iValidB  in  1  requester B write valid
- iAddrB  in  5  requester B register address
- iDataB  in  8  requester B write data
- oReadyB  out  1  requester B accepted this cycle
- oWE  out  1  write strobe to voice bank, one clk wide
- oAddr  out  5  write address to voice bank
- oData  out  8  write data to voice bank
- oBusy  out  1  FIFO non-empty or write in flight
- oDropCnt  out  8  count of dropped out-of-range writes, saturating

Behaviour:
- Reset (async, iRst=1):
  - FIFO count and pointers = 0; gap counter = 0; round-robin priority = A.
  - oWE=0, oAddr=0, oData=0, oDropCnt=0, oBusy=0.
  - Reset mid-transfer discards all queued writes.
- Handshake: a transfer completes when iValidX=1 and oReadyX=1 on the same rising edge. oReadyX is combinational:
  - At most one of oReadyA/oReadyB is high per cycle.
  - Grant requires FIFO not full, or a pop happening in the same cycle (push+pop at full is allowed).
- Arbitration:
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the priority holder; priority then flips to the other port.
  - Priority changes only when both ports were valid in the same cycle.
- Address filter: a granted write with addr > MAX_ADDR is accepted (ready=1) but not queued; oDropCnt increments and saturates at 8'hFF.
- FIFO: entry = {addr, data}; strict FIFO order; pointers wrap modulo DEPTH.
- Issue (pop) occurs when all of these hold:
  - count > 0
  - gap counter = 0
  - clkEn=1, or ISSUE_ON_CLKEN=0
- Issue output timing:
  - oWE, oAddr, oData are registered; oWE=1 for exactly the cycle after the pop decision.
  - oAddr/oData hold their last value while oWE=0.
- Latency: write accepted at edge N into an empty FIFO -> earliest oWE at cycle N+1 when ISSUE_ON_CLKEN=0; with ISSUE_ON_CLKEN=1, one cycle after the first clkEn at or after N+1.
- Gap counter:
  - Loaded with MIN_GAP on each pop; decrements every clk (not only on clkEn) down to 0.
  - With MIN_GAP=0, back-to-back pops on consecutive eligible cycles are allowed.
- Same-cycle push and pop: count unchanged; ordering preserved.
- oBusy = (count != 0) | oWE.
- Writes are never reordered or duplicated; no write is lost except by filter or reset.

Optional Feature:
- Macro SID_WRITE_SHADOW_EN.
- When defined:
  - Adds ports iRdAddr (in, 5) and oRdData (out, 8).
  - Shadow register file of MAX_ADDR+1 bytes, reset to 0 asynchronously.
  - Updated with oAddr/oData in the same cycle oWE=1.
  - oRdData = shadow[iRdAddr], registered, 1-cycle read latency.
  - Addresses > MAX_ADDR read 8'h00.
  - A read of an address being written in the same cycle returns the old value.
- When undefined: the ports and storage are absent; all other behaviour is identical.

Test Plan:
- ISSUE_ON_CLKEN=0, MIN_GAP=0: A writes (5'h04, 8'h41) -> oWE at next cycle with oAddr=5'h04, oData=8'h41; oBusy drops the cycle after.
- A and B valid continuously with distinct data, FIFO never full -> grants alternate A,B,A,B starting with A; oWE sequence is in the same order.
- Hold the issue path stalled (ISSUE_ON_CLKEN=1, clkEn=0) and push 8 writes with DEPTH=8 -> oReadyA=0 on the 9th; assert clkEn for one cycle -> one pop, and the 9th write is accepted in that same cycle.
- B writes addr 5'h1B -> oReadyB=1, no oWE, oDropCnt=1; after 300 such writes oDropCnt=8'hFF.
- MIN_GAP=3, four queued writes -> oWE pulses separated by exactly 3 idle cycles.
- Assert iRst asynchronously with 5 entries queued -> oWE, oBusy, and count go 0 immediately; no further writes issued after release. With SID_WRITE_SHADOW_EN: write 5'h02=8'hA5, then read 5'h02 -> 8'hA5 one cycle later; read 5'h1F -> 8'h00.

Source files
------------

// File: rtl/sid_write_arbiter.sv
// Round-robin arbiter and write FIFO feeding the single SID register-write bus.
// Define SID_WRITE_SHADOW_EN to add a read-back shadow of issued register writes.
module sid_write_arbiter #(
  parameter int         DEPTH          = 8,
  parameter int         MIN_GAP        = 0,
  parameter int         ISSUE_ON_CLKEN = 1,
  parameter logic [4:0] MAX_ADDR       = 5'h18
) (
  input  logic       clk,
  input  logic       iRst,
  input  logic       clkEn,
  input  logic       iValidA,
  input  logic [4:0] iAddrA,
  input  logic [7:0] iDataA,
  output logic       oReadyA,
  input  logic       iValidB,
  input  logic [4:0] iAddrB,
  input  logic [7:0] iDataB,
  output logic       oReadyB,
  output logic       oWE,
  output logic [4:0] oAddr,
  output logic [7:0] oData,
  output logic       oBusy,
  output logic [7:0] oDropCnt
`ifdef SID_WRITE_SHADOW_EN
  ,
  input  logic [4:0] iRdAddr,
  output logic [7:0] oRdData
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    gap_q, gap_d;
  logic          prio_q, prio_d;  // 0: A holds priority, 1: B holds priority
  logic [7:0]    drop_q, drop_d;
  logic          we_q;
  logic [4:0]    addr_q;
  logic [7:0]    data_q;

  logic          pop, can_grant, grant_a, grant_b, push, drop;
  logic [4:0]    sel_addr;
  logic [7:0]    sel_data;

  always_comb begin
    pop       = (count_q != '0) && (gap_q == 8'd0) && (clkEn || (ISSUE_ON_CLKEN == 0));
    can_grant = (count_q != FULL_CNT) || pop;
    grant_a   = can_grant && iValidA && (!iValidB || !prio_q);
    grant_b   = can_grant && iValidB && (!iValidA || prio_q);
    sel_addr  = grant_b ? iAddrB : iAddrA;
    sel_data  = grant_b ? iDataB : iDataA;
    // Out-of-range writes still complete the handshake so the requester never stalls on them.
    push      = (grant_a || grant_b) && (sel_addr <= MAX_ADDR);
    drop      = (grant_a || grant_b) && (sel_addr > MAX_ADDR);

    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    gap_d = gap_q;
    if (pop)
      gap_d = 8'(MIN_GAP);
    else if (gap_q != 8'd0)
      gap_d = gap_q - 8'd1;

    prio_d = (iValidA && iValidB && can_grant) ? ~prio_q : prio_q;
    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {sel_addr, sel_data};
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= 8'd0;
      prio_q   <= 1'b0;
      drop_q   <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gap_q    <= gap_d;
      prio_q   <= prio_d;
      drop_q   <= drop_d;
      we_q     <= pop;
      if (pop)
        {addr_q, data_q} <= mem_q[rd_ptr_q];
    end
  end

  assign oReadyA  = grant_a;
  assign oReadyB  = grant_b;
  assign oWE      = we_q;
  assign oAddr    = addr_q;
  assign oData    = data_q;
  assign oBusy    = (count_q != '0) || we_q;
  assign oDropCnt = drop_q;

`ifdef SID_WRITE_SHADOW_EN
  localparam int SH_N = int'(MAX_ADDR) + 1;

  logic [7:0] shadow_q [SH_N];
  logic [7:0] rd_data_q;

  for (genvar gi = 0; gi < SH_N; gi++) begin : g_shadow
    always_ff @(posedge clk or posedge iRst) begin
      if (iRst)
        shadow_q[gi] <= 8'h00;
      else if (we_q && (addr_q == 5'(gi)))
        shadow_q[gi] <= data_q;
    end
  end

  // Sampled on the same edge as a shadow update, so a colliding read sees the old byte.
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst)
      rd_data_q <= 8'h00;
    else
      rd_data_q <= (iRdAddr <= MAX_ADDR) ? shadow_q[iRdAddr] : 8'h00;
  end

  assign oRdData = rd_data_q;
`endif

endmodule

// File: tb/tb_sid_write_arbiter.sv
// Bench for sid_write_arbiter: a fast instance (no clkEn alignment, no gap) and a slow one
// (clkEn aligned, MIN_GAP=3) share stimulus; a queue model checks both every cycle.
module tb_sid_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkEn = 1'b0;
  logic       vA = 1'b0, vB = 1'b0;
  logic [4:0] aA = 5'd0, aB = 5'd0;
  logic [7:0] dA = 8'd0, dB = 8'd0;

  logic       rdyA [2];
  logic       rdyB [2];
  logic       we_o [2];
  logic       busy_o [2];
  logic [4:0] addr_o [2];
  logic [7:0] data_o [2];
  logic [7:0] drop_o [2];
`ifdef SID_WRITE_SHADOW_EN
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data_o [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sid_write_arbiter #(.DEPTH(8), .MIN_GAP(0), .ISSUE_ON_CLKEN(0), .MAX_ADDR(5'h18)) u_fast (
    .clk(clk), .iRst(rst), .clkEn(clkEn),
    .iValidA(vA), .iAddrA(aA), .iDataA(dA), .oReadyA(rdyA[0]),
    .iValidB(vB), .iAddrB(aB), .iDataB(dB), .oReadyB(rdyB[0]),
    .oWE(we_o[0]), .oAddr(addr_o[0]), .oData(data_o[0]),
    .oBusy(busy_o[0]), .oDropCnt(drop_o[0])
`ifdef SID_WRITE_SHADOW_EN
    , .iRdAddr(rd_addr), .oRdData(rd_data_o[0])
`endif
  );

  sid_write_arbiter #(.DEPTH(8), .MIN_GAP(3), .ISSUE_ON_CLKEN(1), .MAX_ADDR(5'h18)) u_slow (
    .clk(clk), .iRst(rst), .clkEn(clkEn),
    .iValidA(vA), .iAddrA(aA), .iDataA(dA), .oReadyA(rdyA[1]),
    .iValidB(vB), .iAddrB(aB), .iDataB(dB), .oReadyB(rdyB[1]),
    .oWE(we_o[1]), .oAddr(addr_o[1]), .oData(data_o[1]),
    .oBusy(busy_o[1]), .oDropCnt(drop_o[1])
`ifdef SID_WRITE_SHADOW_EN
    , .iRdAddr(rd_addr), .oRdData(rd_data_o[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the FIFO is a plain queue; each instance has its own issue rules.
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam bit IOC = (gi == 1);
    localparam int MG  = (gi == 1) ? 3 : 0;
    logic [12:0] q[$];
    logic [12:0] e;
    int          gap, drops;
    bit          prio, we, pop, ok, ga, gb;
    logic [4:0]  ad, a;
    logic [7:0]  da;

    initial begin
      gap = 0; drops = 0; prio = 0; we = 0; ad = 0; da = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          q.delete(); gap = 0; drops = 0; prio = 0; we = 0; ad = 0; da = 0;
          continue;
        end
        pop = (q.size() > 0) && (gap == 0) && (clkEn || !IOC);
        ok  = (q.size() < 8) || pop;
        ga  = ok && vA && (!vB || !prio);
        gb  = ok && vB && (!vA || prio);
        check($sformatf("dut%0d.readyA", gi), rdyA[gi], ga);
        check($sformatf("dut%0d.readyB", gi), rdyB[gi], gb);
        check($sformatf("dut%0d.we", gi), we_o[gi], we);
        check($sformatf("dut%0d.addr", gi), addr_o[gi], ad);
        check($sformatf("dut%0d.data", gi), data_o[gi], da);
        check($sformatf("dut%0d.busy", gi), busy_o[gi], (q.size() != 0) || we);
        check($sformatf("dut%0d.drops", gi), drop_o[gi], drops);
        @(posedge clk);
        if (rst) continue;
        if (pop) begin
          e  = q.pop_front();
          ad = e[12:8];
          da = e[7:0];
          we = 1;
          gap = MG;
          $display("[%0t] dut%0d issue addr=%02h data=%02h", $time, gi, ad, da);
        end else begin
          we = 0;
          if (gap > 0) gap--;
        end
        if (ga || gb) begin
          a = ga ? aA : aB;
          if (a > 5'h18) begin
            if (drops < 255) drops++;
          end else begin
            q.push_back(ga ? {aA, dA} : {aB, dB});
          end
        end
        if (vA && vB && ok) prio = !prio;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 2; k++) begin
      check("reset.we", we_o[k], 0);
      check("reset.busy", busy_o[k], 0);
      check("reset.addr", addr_o[k], 0);
      check("reset.drop", drop_o[k], 0);
    end
    rst = 1'b0;

    // Single write from A
    vA = 1'b1; aA = 5'h04; dA = 8'h41;
    tick();
    vA = 1'b0;
    check("t1.we_pre", we_o[0], 0);
    tick();
    check("t1.we", we_o[0], 1);
    check("t1.addr", addr_o[0], 5'h04);
    check("t1.data", data_o[0], 8'h41);
    check("t1.busy", busy_o[0], 1);
    tick();
    check("t1.we_off", we_o[0], 0);
    check("t1.busy_off", busy_o[0], 0);
    check("t1.slow_held", busy_o[1], 1);
    clkEn = 1'b1;
    tick();
    clkEn = 1'b0;
    check("t1.slow_we", we_o[1], 1);
    check("t1.slow_addr", addr_o[1], 5'h04);
    tick();
    check("t1.slow_idle", busy_o[1], 0);

    // Both requesters valid: grants alternate starting with A
    for (int i = 0; i < 6; i++) begin
      vA = 1'b1; aA = 5'(i);     dA = 8'hA0 + 8'(i);
      vB = 1'b1; aB = 5'(8 + i); dB = 8'hB0 + 8'(i);
      #2;
      check("t2.readyA", rdyA[0], (i % 2) == 0);
      check("t2.readyB", rdyB[0], (i % 2) == 1);
      check("t2.slow_readyA", rdyA[1], (i % 2) == 0);
      if (i >= 2) begin
        check("t2.we", we_o[0], 1);
        check("t2.order", addr_o[0], ((i - 2) % 2 == 0) ? (i - 2) : (8 + i - 2));
      end
      tick();
    end
    vA = 1'b0; vB = 1'b0;
    check("t2.order4", addr_o[0], 5'h04);
    check("t2.data4", data_o[0], 8'hA4);
    tick();
    check("t2.order5", addr_o[0], 5'h0D);
    check("t2.data5", data_o[0], 8'hB5);

    // Drain the slow instance, then fill it while stalled
    clkEn = 1'b1;
    repeat (30) tick();
    clkEn = 1'b0;
    check("t3.drained", busy_o[1], 0);
    for (int i = 0; i < 9; i++) begin
      vA = 1'b1; aA = 5'h10 + 5'(i); dA = 8'hC0 + 8'(i);
      #2;
      if (i < 8) begin
        check("t3.ready", rdyA[1], 1);
      end else begin
        check("t3.full", rdyA[1], 0);
        clkEn = 1'b1;
        #1;
        check("t3.push_pop", rdyA[1], 1);
      end
      tick();
    end
    vA = 1'b0;
    check("t3.pop_we", we_o[1], 1);
    check("t3.pop_addr", addr_o[1], 5'h10);
    check("t3.pop_data", data_o[1], 8'hC0);

    // MIN_GAP=3: pulses four cycles apart
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t4.gap_we", we_o[1], (k % 4) == 0);
      if ((k % 4) == 0) check("t4.gap_addr", addr_o[1], 5'h10 + k / 4);
    end

    // Asynchronous reset with five writes still queued
    clkEn = 1'b0;
    check("t5.busy_pre", busy_o[1], 1);
    check("t5.we_pre", we_o[1], 1);
    #2 rst = 1'b1;
    #1;
    check("t5.we_rst", we_o[1], 0);
    check("t5.busy_rst", busy_o[1], 0);
    check("t5.addr_rst", addr_o[1], 0);
    tick();
    tick();
    rst = 1'b0;
    clkEn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5.no_issue", we_o[1], 0);
      check("t5.idle", busy_o[1], 0);
    end

    // Out-of-range writes are accepted and counted, saturating
    vB = 1'b1; aB = 5'h1B; dB = 8'h77;
    #1;
    check("t6.readyB", rdyB[0], 1);
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (j == 1) begin
        check("t6.drop1", drop_o[0], 8'h01);
        check("t6.drop1_slow", drop_o[1], 8'h01);
      end
      if (j == 254) check("t6.drop254", drop_o[0], 8'hFE);
      if (j == 255) check("t6.drop255", drop_o[0], 8'hFF);
      if (j == 300) check("t6.drop_sat", drop_o[1], 8'hFF);
      if (j < 4) check("t6.no_we", we_o[0], 0);
    end
    vB = 1'b0;
    tick();

`ifdef SID_WRITE_SHADOW_EN
    vA = 1'b1; aA = 5'h02; dA = 8'hA5;
    tick();
    vA = 1'b0;
    tick();
    check("sh.we", we_o[0], 1);
    tick();
    rd_addr = 5'h02;
    tick();
    check("sh.read", rd_data_o[0], 8'hA5);
    rd_addr = 5'h1F;
    tick();
    check("sh.read_oob", rd_data_o[0], 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
